uart_tx_serializer: RTL

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx_serializer.sv | 101 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional parity (macro UART_TX_PARITY_EN) adds the PARITY state.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, wraps, and
// pulses bit_tick on the last count of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear)  cnt <= '0;
    else if (enable)   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign bit_tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter; with UART_TX_PARITY_EN defined it sends 8E1.
// o_tx is registered so the line never glitches.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [UART_DATA_W-1:0] i_data,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  uart_state_t            state, state_nxt;
  logic [UART_DATA_W-1:0] shreg;
  logic [2:0]             idx;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   accept, tick;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign accept = (state == IDLE) && i_start;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (accept),
    .enable   (state != IDLE),
    .bit_tick (tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (i_start) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && idx == 3'd7) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
`else
      DATA:   if (tick && idx == 3'd7) state_nxt = STOP;
`endif
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is computed for the state being entered, then registered.
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state == STOP) && tick;
    case (state_nxt)
      START:  tx_d = 1'b0;
      DATA:   tx_d = (state == DATA && tick) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      shreg  <= '0;
      idx    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      tx_q   <= tx_d;
      done_q <= done_d;
      if (accept) begin
        shreg <= i_data;
        idx   <= '0;
`ifdef UART_TX_PARITY_EN
        par_q <= ^i_data;
`endif
      end else if (state == DATA && tick) begin
        shreg <= shreg >> 1;
        idx   <= idx + 3'd1;
      end
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state != IDLE);
  assign o_done = done_q;

endmodule
